score_display: RTL and testbench
================================

Name: score_display

Overview:
- Parametrised successor to the two-digit score readout used on the Pong board.
- Accepts a binary score, converts it to BCD sequentially with iterative double-dabble, and drives DIGITS active-low seven-segment outputs.
- Adds leading-zero blanking, overflow indication and a blink mode. These features let one instance per player replace the fixed per-digit decoders at chip level.

Parameters:
- DIGITS, 2, number of seven-segment digits driven (1..8).
- BIN_W, 7, width of the binary input value (1..27).
- BLINK_DIV, 25_000_000, CLOCK_50 cycles per blink half-period (>=2).

Ports:
- CLOCK_50  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- value  input  BIN_W  binary score, sampled only when a load is accepted.
- load  input  1  request to convert and display value.
- lz_blank  input  1  leading-zero blanking enable, applied live.
- blink_en  input  1  blink enable, applied live.
- busy  output  1  conversion in progress; loads are ignored while high.
- done  output  1  one-cycle pulse when a new value is latched for display.
- seg  output  [DIGITS-1:0][6:0]  active-low segments per digit, gfedcba order; seg[0] is the least significant digit.

Behaviour:
- One clock domain. reset_n asserts asynchronously and deasserts synchronously at the chip level.
- Reset values:
  - seg = all 7'h7F (blank); busy = 0; done = 0.
  - State IDLE; shift counter = 0; latched digits = 0.
  - Overflow flag = 0; "displayed" flag = 0 (blank until the first done).
  - Blink counter = 0; blink phase = visible.
- FSM states: IDLE, CONVERT, LATCH.
- IDLE:
  - load=1 captures value into the binary shift register and clears the BCD register (DIGITS*4 bits).
  - Computes overflow = (value > 10^DIGITS-1); the comparison is wide enough for any BIN_W.
  - Loads counter = BIN_W and moves to CONVERT.
  - busy becomes 1 in the next cycle.
- CONVERT, each cycle:
  - Add 3 to every BCD nibble >= 5.
  - Then shift {bcd, bin} left by 1.
  - Decrement counter; when the counter reaches 1 this cycle, go to LATCH.
  - Exactly BIN_W shift cycles occur.
- LATCH, one cycle:
  - Copy BCD into the displayed-digit register and copy the overflow flag.
  - Set displayed = 1, pulse done = 1, set busy = 0, return to IDLE.
- Latency, with load accepted at edge T:
  - busy is high for cycles T+1 .. T+BIN_W+1.
  - done pulses at T+BIN_W+1.
  - seg shows the new value from T+BIN_W+2 (seg is registered).
- load while busy is ignored and not queued. load in the LATCH cycle is also ignored.
- A new load may be accepted in the IDLE cycle right after LATCH.
- seg register, updated every cycle, in priority order:
  1. displayed=0, or blink_en=1 with blink phase blank: all digits 7'h7F.
  2. Overflow: all digits 7'b011_1111 (dash).
  3. Otherwise each digit is encoded from its BCD nibble. With lz_blank=1, digit i>0 is blanked when it and all higher digits are 0. Digit 0 is never blanked.
- BCD nibble codes 10..15 encode to blank (unreachable in normal operation).
- Blink:
  - While blink_en=1, the counter counts 0..BLINK_DIV-1 and wraps; the phase toggles on each wrap, starting with visible.
  - While blink_en=0, the counter is held at 0 and the phase is forced to visible.
- reset_n low mid-conversion aborts the conversion immediately. All outputs return to reset values and no done is emitted.
- value changes after the accept cycle have no effect.

Decomposition:
- Package score_display_pkg holds:
  - state enum typedef {IDLE, CONVERT, LATCH};
  - constants SEG_BLANK = 7'h7F and SEG_DASH = 7'b011_1111;
  - constant function pow10(n), used for the overflow limit.
- One combinational sub-module, seven_seg_encode: 4-bit BCD in, 7-bit active-low segments out; codes 0-9 as on the board, 10-15 blank. Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset: hold reset_n=0 → seg = {7'h7F,7'h7F}, busy=0, done=0. Release with no load → seg stays blank.
- DIGITS=2, BIN_W=7: load 42 at T → busy for T+1..T+8, done at T+8 only. From T+9: seg[1]=7'b001_1001, seg[0]=7'b010_0100.
- Load 7 with lz_blank=1 → seg[1]=7'h7F, seg[0]=7'b111_1000. Toggle lz_blank=0 → next cycle seg[1]=7'b100_0000.
- Load 100 (>99) → done pulses; seg[1]=seg[0]=7'b011_1111. Then load 0 → seg[0]=7'b100_0000.
- Load 42, then load 99 at T+3 → second load ignored, exactly one done, display 42. Load 99 at T+9 → accepted, display 99.
- BLINK_DIV=4: blink_en=1 → seg alternates 4 cycles visible / 4 cycles blank. Then assert reset_n=0 at T+4 of a new conversion → seg blank and busy=0 immediately, with no done.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types, segment constants and the overflow-limit helper for score_display.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LATCH   = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;

    // 10**n, evaluated at elaboration time for the overflow limit
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_encode.sv
// BCD nibble to active-low gfedcba segments; codes 10..15 are blank.
module seven_seg_encode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    // Board digit patterns
    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0: seg_c = 7'b100_0000;
            4'd1: seg_c = 7'b111_1001;
            4'd2: seg_c = 7'b010_0100;
            4'd3: seg_c = 7'b011_0000;
            4'd4: seg_c = 7'b001_1001;
            4'd5: seg_c = 7'b001_0010;
            4'd6: seg_c = 7'b000_0010;
            4'd7: seg_c = 7'b111_1000;
            4'd8: seg_c = 7'b000_0000;
            4'd9: seg_c = 7'b001_0000;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Binary score to multi-digit seven-segment readout via sequential double-dabble,
// with leading-zero blanking, overflow dashes and blink.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned BIN_W     = 7,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [BIN_W-1:0]        value,
    input  logic                    load,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    done,
    output logic [DIGITS-1:0][6:0]  seg
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [DIGITS-1:0][3:0]   bcd_q, bcd_d, bcd_adj;
    logic [DIGITS-1:0][3:0]   digits_q, digits_d;
    logic                     ovf_cap_q, ovf_cap_d;
    logic                     ovf_q, ovf_d;
    logic                     disp_q, disp_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [BLK_W-1:0]         blk_cnt_q, blk_cnt_d;
    logic                     blk_phase_q, blk_phase_d;
    logic [DIGITS-1:0][6:0]   seg_q, seg_d;
    logic [DIGITS-1:0][6:0]   enc_c;
    logic [BCD_W+BIN_W-1:0]   shift_c;
    logic                     higher_nz;

    // Register bank
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            digits_q    <= '0;
            ovf_cap_q   <= 1'b0;
            ovf_q       <= 1'b0;
            disp_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
            seg_q       <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            digits_q    <= digits_d;
            ovf_cap_q   <= ovf_cap_d;
            ovf_q       <= ovf_d;
            disp_q      <= disp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            blk_cnt_q   <= blk_cnt_d;
            blk_phase_q <= blk_phase_d;
            seg_q       <= seg_d;
        end
    end

    // Conversion FSM: accept, add-3/shift BIN_W times, then latch for display
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        digits_d  = digits_q;
        ovf_cap_d = ovf_cap_q;
        ovf_d     = ovf_q;
        disp_d    = disp_q;
        busy_d    = (state_q != IDLE);
        done_d    = (state_q == LATCH);
        bcd_adj   = bcd_q;
        shift_c   = '0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d     = value;
                    bcd_d     = '0;
                    ovf_cap_d = (64'(value) > MAX_VAL);
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
                end
                shift_c = {bcd_adj, bin_q} << 1;
                bcd_d   = shift_c[BCD_W+BIN_W-1:BIN_W];
                bin_d   = shift_c[BIN_W-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                digits_d = bcd_q;
                ovf_d    = ovf_cap_q;
                disp_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink divider: free-running half-period counter while enabled
    always_comb begin
        blk_cnt_d   = '0;
        blk_phase_d = 1'b0;
        if (blink_en) begin
            if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blk_cnt_d   = '0;
                blk_phase_d = ~blk_phase_q;
            end else begin
                blk_cnt_d   = blk_cnt_q + BLK_W'(1);
                blk_phase_d = blk_phase_q;
            end
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_enc
        seven_seg_encode u_enc (
            .bcd   (digits_q[g]),
            .seg_c (enc_c[g])
        );
    end

    // Segment select: blank/blink, then overflow dashes, then digits with optional LZ blanking
    always_comb begin
        seg_d     = {DIGITS{SEG_BLANK}};
        higher_nz = 1'b0;
        if (!disp_q || (blink_en && blk_phase_q)) begin
            seg_d = {DIGITS{SEG_BLANK}};
        end else if (ovf_q) begin
            seg_d = {DIGITS{SEG_DASH}};
        end else begin
            for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
                higher_nz = higher_nz | (digits_q[i] != 4'd0);
                if (lz_blank && (i != 0) && !higher_nz) begin
                    seg_d[i] = SEG_BLANK;
                end else begin
                    seg_d[i] = enc_c[i];
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Randomised self-checking bench for score_display against a decimal-arithmetic display model.
module tb_score_display;

    localparam int unsigned DIGITS    = 2;
    localparam int unsigned BIN_W     = 7;
    localparam int unsigned BLINK_DIV = 4;
    localparam int          MAX_SHOW  = 99;

    typedef logic [DIGITS-1:0][6:0] seg_t;

    logic             clk;
    logic             rst_n;
    logic [BIN_W-1:0] value;
    logic             load;
    logic             lz_blank;
    logic             blink_en;
    logic             busy;
    logic             done;
    seg_t             seg;

    int checks;
    int errors;

    // Display model: what the readout should currently show
    bit m_disp;
    int m_val;
    bit m_ovf;

    score_display #(
        .DIGITS    (DIGITS),
        .BIN_W     (BIN_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .value    (value),
        .load     (load),
        .lz_blank (lz_blank),
        .blink_en (blink_en),
        .busy     (busy),
        .done     (done),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            9: return 7'b001_0000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic seg_t exp_seg(input bit lz, input bit blank);
        seg_t r;
        int   tens;
        int   ones;
        if (!m_disp || blank) begin
            r[1] = 7'h7F;
            r[0] = 7'h7F;
        end else if (m_ovf) begin
            r[1] = 7'b011_1111;
            r[0] = 7'b011_1111;
        end else begin
            ones = m_val % 10;
            tens = (m_val / 10) % 10;
            r[0] = digit_code(ones);
            r[1] = (lz && tens == 0) ? 7'h7F : digit_code(tens);
        end
        return r;
    endfunction

    // Issue one load and follow the busy/done protocol; extra_at>0 pulses a second load before edge T+extra_at
    task automatic apply_load(input int v, input bit lz, input int extra_at, input string tag);
        seg_t e;
        value    = BIN_W'(v);
        lz_blank = lz;
        load     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
        value = BIN_W'($urandom);
        e = exp_seg(lz, 1'b0);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || seg !== e) begin
            errors++;
            $display("FAIL %s accept-cycle busy=%b done=%b seg=%h expected busy=0 done=0 seg=%h",
                     tag, busy, done, seg, e);
        end
        for (int k = 1; k <= int'(BIN_W) + 1; k++) begin
            load = (k == extra_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            load = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== (k == int'(BIN_W) + 1) || seg !== e) begin
                errors++;
                $display("FAIL %s cycle T+%0d busy=%b done=%b seg=%h expected busy=1 done=%b seg=%h",
                         tag, k, busy, done, seg, (k == int'(BIN_W) + 1), e);
            end
        end
        m_disp = 1'b1;
        m_val  = v;
        m_ovf  = (v > MAX_SHOW);
    endtask

    task automatic check_shown(input string tag);
        seg_t e;
        @(negedge clk);
        e = exp_seg(lz_blank, 1'b0);
        checks++;
        if (seg !== e || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s seg=%h busy=%b done=%b expected seg=%h busy=0 done=0",
                     tag, seg, busy, done, e);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        lz_blank = 1'b0;
        blink_en = 1'b0;
        m_disp   = 1'b0;
        m_val    = 0;
        m_ovf    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== {7'h7F, 7'h7F} || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold seg=%h busy=%b done=%b expected seg=3fff busy=0 done=0",
                     seg, busy, done);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (seg !== {7'h7F, 7'h7F} || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release seg=%h busy=%b done=%b expected seg=3fff busy=0 done=0",
                     seg, busy, done);
        end
    endtask

    task automatic test_basic();
        apply_load(42, 1'b0, 0, "load42");
        check_shown("show42");
        checks++;
        if (seg[1] !== 7'b001_1001 || seg[0] !== 7'b010_0100) begin
            errors++;
            $display("FAIL digits42 seg1=%b seg0=%b expected seg1=0011001 seg0=0100100", seg[1], seg[0]);
        end
    endtask

    task automatic test_lz_blank();
        apply_load(7, 1'b1, 0, "load7");
        check_shown("show7_lz");
        lz_blank = 1'b0;
        check_shown("show7_nolz");
        checks++;
        if (seg[1] !== 7'b100_0000) begin
            errors++;
            $display("FAIL lz_live seg1=%b expected 1000000", seg[1]);
        end
    endtask

    task automatic test_overflow();
        apply_load(100, 1'b0, 0, "load100");
        check_shown("show_dash");
        apply_load(0, 1'b0, 0, "load0");
        check_shown("show0");
    endtask

    task automatic test_back_to_back();
        apply_load(42, 1'b0, 3, "b2b_first");
        apply_load(99, 1'b0, 0, "b2b_second");
        check_shown("show99");
    endtask

    task automatic test_random();
        int v;
        bit lz;
        for (int n = 0; n < 20; n++) begin
            v  = int'($urandom_range(0, (1 << BIN_W) - 1));
            lz = 1'($urandom_range(0, 1));
            apply_load(v, lz, 0, "rand_load");
            check_shown("rand_show");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_blink();
        seg_t e;
        bit   blank;
        apply_load(58, 1'b0, 0, "blink_load");
        check_shown("blink_pre");
        blink_en = 1'b1;
        for (int k = 1; k <= 4 * int'(BLINK_DIV); k++) begin
            @(negedge clk);
            blank = (((k - 1) / int'(BLINK_DIV)) % 2) == 1;
            e = exp_seg(lz_blank, blank);
            checks++;
            if (seg !== e) begin
                errors++;
                $display("FAIL blink k=%0d seg=%h expected %h", k, seg, e);
            end
        end
        blink_en = 1'b0;
        check_shown("blink_off");
    endtask

    task automatic test_reset_abort();
        value = BIN_W'(55);
        load  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_disp = 1'b0;
        checks++;
        if (seg !== {7'h7F, 7'h7F} || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort seg=%h busy=%b done=%b expected seg=3fff busy=0 done=0",
                     seg, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || seg !== {7'h7F, 7'h7F}) begin
                errors++;
                $display("FAIL abort_after k=%0d done=%b busy=%b seg=%h expected done=0 busy=0 seg=3fff",
                         k, done, busy, seg);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_lz_blank();
        test_overflow();
        test_back_to_back();
        test_random();
        test_blink();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
